// File: rtl/vdma_wr_arbiter.sv
// vdma_wr_arbiter: round-robin sharing of one AXI write core between NUM_CH
// stream channels, one burst per grant.
// Optional watchdog: define VDMA_ARB_WDT_EN to add wdt_err/wdt_ch.
module vdma_wr_arbiter #(
  parameter int NUM_CH    = 4,
  parameter int CHSIZE    = 2,
  parameter int ASIZE     = 29,
  parameter int LSIZE     = 9,
  parameter int AXI_DSIZE = 256
`ifdef VDMA_ARB_WDT_EN
  , parameter int WDT_CYCLES = 4096
`endif
) (
  input  logic                          axi_aclk,
  input  logic                          axi_rst,
  input  logic [NUM_CH-1:0]             ch_req,
  input  logic [NUM_CH*LSIZE-1:0]       ch_len,
  input  logic [NUM_CH*ASIZE-1:0]       ch_addr,
  input  logic [NUM_CH*AXI_DSIZE-1:0]   ch_wdata,
  output logic [NUM_CH-1:0]             ch_resp,
  output logic [NUM_CH-1:0]             ch_done,
  output logic [NUM_CH-1:0]             ch_pull_en,
  output logic                          core_write_req,
  output logic [LSIZE-1:0]              core_req_len,
  output logic [ASIZE-1:0]              core_req_addr,
  input  logic                          core_req_resp,
  input  logic                          core_req_done,
  input  logic                          core_pull_en,
  input  logic                          axi_wready,
  output logic [AXI_DSIZE-1:0]          axi_wdata,
  output logic [CHSIZE-1:0]             grant_id,
  output logic                          busy,
  output logic                          beat_err
`ifdef VDMA_ARB_WDT_EN
  , output logic                        wdt_err,
  output logic [CHSIZE-1:0]             wdt_ch
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, BUSY} state_t;

  state_t                r_state, w_nxt;
  logic [CHSIZE-1:0]     r_rr_ptr, r_grant_id, w_sel;
  logic [LSIZE-1:0]      r_len;
  logic [ASIZE-1:0]      r_addr;
  logic [LSIZE:0]        r_beat_cnt;
  logic                  r_beat_err;
  logic [2*NUM_CH-1:0]   w_dbl;
  logic [NUM_CH-1:0]     w_rot, w_onehot;
  logic                  w_found, w_beat, w_grant;

  // Requests rotated so bit 0 is the channel at rr_ptr; first set bit wins.
  assign w_dbl = {ch_req, ch_req} >> r_rr_ptr;
  assign w_rot = w_dbl[NUM_CH-1:0];

  // Round-robin priority scan starting at rr_ptr
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_sel   = CHSIZE'((int'(r_rr_ptr) + k) % NUM_CH);
      end
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_oh
    assign w_onehot[i] = (r_grant_id == CHSIZE'(i));
  end

  assign w_grant = (r_state == IDLE) && w_found;
  assign w_beat  = (r_state == BUSY) && core_pull_en && axi_wready;

  // State register
  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) r_state <= IDLE;
    else         r_state <= w_nxt;
  end

  // Next-state: resp only counts in REQ, done only in BUSY
  always_comb begin
    w_nxt = r_state;
    case (r_state)
      IDLE:    if (w_found)       w_nxt = REQ;
      REQ:     if (core_req_resp) w_nxt = BUSY;
      BUSY:    if (core_req_done) w_nxt = IDLE;
      default:                    w_nxt = IDLE;
    endcase
  end

  // Grant capture and round-robin pointer advance after each burst
  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      r_grant_id <= '0;
      r_len      <= '0;
      r_addr     <= '0;
      r_rr_ptr   <= '0;
    end else begin
      if (w_grant) begin
        r_grant_id <= w_sel;
        r_len      <= ch_len[w_sel*LSIZE +: LSIZE];
        r_addr     <= ch_addr[w_sel*ASIZE +: ASIZE];
      end
      if (r_state == BUSY && core_req_done)
        r_rr_ptr <= CHSIZE'((int'(r_grant_id) + 1) % NUM_CH);
    end
  end

  // Beat counter and sticky length-mismatch flag checked at done
  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      r_beat_cnt <= '0;
      r_beat_err <= 1'b0;
    end else begin
      if (w_grant)     r_beat_cnt <= '0;
      else if (w_beat) r_beat_cnt <= r_beat_cnt + 1'b1;
      if (r_state == BUSY && core_req_done &&
          (r_beat_cnt + {{LSIZE{1'b0}}, w_beat}) != ({1'b0, r_len} + 1'b1))
        r_beat_err <= 1'b1;
    end
  end

  // Per-channel handshakes steered to the granted channel only
  always_comb begin
    ch_resp    = w_onehot & {NUM_CH{(r_state == REQ)  && core_req_resp}};
    ch_done    = w_onehot & {NUM_CH{(r_state == BUSY) && core_req_done}};
    ch_pull_en = w_onehot & {NUM_CH{w_beat}};
  end

  assign core_write_req = (r_state == REQ);
  assign core_req_len   = r_len;
  assign core_req_addr  = r_addr;
  assign grant_id       = r_grant_id;
  assign busy           = (r_state != IDLE);
  assign beat_err       = r_beat_err;
  assign axi_wdata      = ch_wdata[r_grant_id*AXI_DSIZE +: AXI_DSIZE];

`ifdef VDMA_ARB_WDT_EN
  localparam int WW = $clog2(WDT_CYCLES + 1);
  logic [WW-1:0] r_wdt_cnt;
  logic          r_wdt_err;
  logic [CHSIZE-1:0] r_wdt_ch;

  // Watchdog: counts cycles spent in one non-idle state; flags but never aborts
  always_ff @(posedge axi_aclk or posedge axi_rst) begin
    if (axi_rst) begin
      r_wdt_cnt <= '0;
      r_wdt_err <= 1'b0;
      r_wdt_ch  <= '0;
    end else if (w_nxt != r_state || r_state == IDLE) begin
      r_wdt_cnt <= '0;
    end else begin
      if (r_wdt_cnt == WW'(WDT_CYCLES - 1)) begin
        r_wdt_err <= 1'b1;
        r_wdt_ch  <= r_grant_id;
      end else begin
        r_wdt_cnt <= r_wdt_cnt + 1'b1;
      end
    end
  end

  assign wdt_err = r_wdt_err;
  assign wdt_ch  = r_wdt_ch;
`endif

endmodule
